div_ctrl: RTL and testbench
===========================

// Module: div_ctrl
// PURPOSE
//  Sequencer between the EX-stage ALU and the two AXI-Stream divider IPs: signed
//  (div_gen_0) and unsigned (div_gen_1). Accepts one div/mod request at a time
//  and drives per-channel dividend/divisor tvalid under full AXIS rules. Captures
//  the quotient or remainder and returns it on a valid/ready response port.
//  Handles pipeline flush by draining the in-flight IP result and discarding it.
// PARAMETERS
//  DW  32  operand/result width; IP dout is 2*DW = {quotient, remainder}
// PORTS
//  clk                  in   1     core clock, the only clock
//  reset                in   1     synchronous, active-high
//  req_valid            in   1     EX stage holds a div/mod op
//  req_ready            out  1     controller can accept a request
//  req_op               in   4     one-hot {umod,udiv,mod,div}
//  req_src1             in   DW    dividend (rj)
//  req_src2             in   DW    divisor (rk)
//  flush                in   1     cancel the current op (exception/ertn)
//  resp_valid           out  1     result available
//  resp_ready           in   1     EX/MEM accepts the result
//  resp_result          out  DW    quotient or remainder, per the latched op
//  busy                 out  1     state != IDLE
//  div_tdata_a          out  DW    dividend tdata, shared by both IPs
//  div_tdata_b          out  DW    divisor tdata, shared by both IPs
//  s_dvd_tvalid         out  1     signed IP dividend tvalid
//  s_dvs_tvalid         out  1     signed IP divisor tvalid
//  s_dvd_tready         in   1     signed IP dividend tready
//  s_dvs_tready         in   1     signed IP divisor tready
//  s_dout_tdata         in   2*DW  signed IP result {quot, rem}
//  s_dout_tvalid        in   1     signed IP result valid
//  u_dvd_tvalid/u_dvs_tvalid/u_dvd_tready/u_dvs_tready/u_dout_tdata/u_dout_tvalid
//                       same as s_* above, for the unsigned IP
// BEHAVIOUR
//  Reset: state=IDLE; all tvalid, resp_valid, busy=0; req_ready=1;
//   resp_result, tdata, and the latched op all 0.
//   The top level ties the IP aresetn to ~reset, so no stale IP output
//   survives a reset.
//  States: IDLE, ISSUE, WAIT, DONE, DRAIN.
//  IDLE: req_ready=1.
//   - req_valid & ~flush: latch op and operands (shared tdata driven from the
//     latches); go to ISSUE.
//   - An IP dout_tvalid seen in IDLE is ignored.
//  ISSUE: assert dvd/dvs tvalid of the unit selected by the op (div/mod ->
//   signed, udiv/umod -> unsigned). Tvalid starts the cycle after acceptance.
//   - Each channel drops its tvalid the cycle after its own handshake
//     (tvalid & tready). Channels may complete in different cycles.
//   - tvalid never drops before its handshake and tdata stays stable; flush
//     does not override this.
//   - Once both channels are done: go to WAIT, or to DRAIN if flush was seen
//     in ISSUE (flush_pend).
//  WAIT: watch only the selected unit's dout_tvalid; the other unit's output is
//   ignored.
//   - On dout_tvalid: resp_result <= div/udiv ? tdata[2DW-1:DW] : tdata[DW-1:0];
//     go to DONE.
//   - If flush or flush_pend at that point: discard and go to IDLE.
//   - flush without dout_tvalid: go to DRAIN.
//  DRAIN: on the selected dout_tvalid, discard and go to IDLE.
//   req_ready stays 0 until then.
//  DONE: resp_valid=1 and resp_result held stable.
//   - resp_ready: go to IDLE.
//   - flush: resp_valid drops next cycle; go to IDLE.
//  Latency: request accepted at cycle T; tvalid at T+1.
//   With immediate tready and IP latency L, resp_valid rises at T+2+L.
//  Divide-by-zero: the IP result is passed through unchanged (architecturally
//   undefined). No trap.
//  A second request is never accepted while busy. A back-to-back request waits
//   one cycle in IDLE.
// STRUCTURE
//  Shared package div_pkg:
//   - state encoding localparams
//   - op one-hot bit indices DIV=0, MOD=1, UDIV=2, UMOD=3
//   - helper func op_is_unsigned()
//  Sub-module axis_issue_slot: one tvalid hold/drop tracker per channel
//   (tvalid, done flag). Four instances, or two muxed per unit.
//  FSM and result capture are inline.
// TESTING
//  1. div -7 / 2 (signed), model L=4:
//     -> only s_* tvalid asserted; resp_result=0xFFFFFFFD at T+6.
//  2. umod 0xFFFFFFFF % 10:
//     -> only u_* tvalid asserted; resp_result=5; s_dout_tvalid pulse mid-op
//        is ignored.
//  3. s_dvs_tready low 3 cycles, s_dvd_tready high:
//     -> dvd tvalid drops after 1 cycle; dvs tvalid and tdata held stable
//        3 cycles; WAIT is entered only after both handshakes.
//  4. flush in WAIT:
//     -> DRAIN; resp_valid never rises; req_ready=1 the cycle after
//        dout_tvalid.
//  5. flush in ISSUE with tready low:
//     -> tvalid held until the handshake, then DRAIN then IDLE; the next
//        request mod 17 % 5 returns 2.
//  6. resp_ready low 5 cycles in DONE:
//     -> resp_valid/result stable; reset mid-WAIT -> all outputs at reset
//        values next cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the divider sequencer.
// State encoding, op one-hot bit indices, op decode helpers.
package div_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    DONE  = ST_DONE,
    DRAIN = ST_DRAIN
  } state_t;

  localparam int OP_DIV  = 0;
  localparam int OP_MOD  = 1;
  localparam int OP_UDIV = 2;
  localparam int OP_UMOD = 3;

  function automatic logic op_is_unsigned(
    input logic [3:0] op
  );
    return op[OP_UDIV] | op[OP_UMOD];
  endfunction

  function automatic logic op_is_quot(
    input logic [3:0] op
  );
    return op[OP_DIV] | op[OP_UDIV];
  endfunction

endpackage

// File: rtl/axis_issue_slot.sv
// AXI-Stream tvalid tracker for one input channel.
// Ports: clk, reset, start (load), tready in; tvalid, hs, done out.
module axis_issue_slot (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic tready,
  output logic tvalid,
  output logic hs,
  output logic done
);

  assign hs = tvalid & tready;

  // tvalid holds until its own handshake; nothing else drops it
  always_ff @(posedge clk) begin
    if (reset) begin
      tvalid <= 1'b0;
      done   <= 1'b0;
    end else if (start) begin
      tvalid <= 1'b1;
      done   <= 1'b0;
    end else if (hs) begin
      tvalid <= 1'b0;
      done   <= 1'b1;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between the ALU and the signed/unsigned AXIS divider IPs.
// Ports: req_* in, resp_* out, flush, busy, shared tdata, s_*/u_* AXIS.
module div_ctrl
  import div_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_op,
  input  logic [DW-1:0] req_src1,
  input  logic [DW-1:0] req_src2,
  input  logic          flush,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_result,
  output logic          busy,
  output logic [DW-1:0] div_tdata_a,
  output logic [DW-1:0] div_tdata_b,
  output logic          s_dvd_tvalid,
  output logic          s_dvs_tvalid,
  input  logic          s_dvd_tready,
  input  logic          s_dvs_tready,
  input  logic [2*DW-1:0] s_dout_tdata,
  input  logic          s_dout_tvalid,
  output logic          u_dvd_tvalid,
  output logic          u_dvs_tvalid,
  input  logic          u_dvd_tready,
  input  logic          u_dvs_tready,
  input  logic [2*DW-1:0] u_dout_tdata,
  input  logic          u_dout_tvalid
);

  state_t state_q, state_d;
  logic [3:0]    op_q;
  logic [DW-1:0] a_q, b_q;
  logic [DW-1:0] res_q;
  logic          pend_q;

  logic uns, accept, both_done;
  logic dvd_v, dvd_hs, dvd_done;
  logic dvs_v, dvs_hs, dvs_done;
  logic dout_v;
  logic [2*DW-1:0] dout_d;

  assign uns    = op_is_unsigned(op_q);
  assign accept = (state_q == IDLE) & req_valid & ~flush;

  // one slot pair, routed to the unit chosen by the latched op
  axis_issue_slot u_dvd (
    .clk    (clk),
    .reset  (reset),
    .start  (accept),
    .tready (uns ? u_dvd_tready : s_dvd_tready),
    .tvalid (dvd_v),
    .hs     (dvd_hs),
    .done   (dvd_done)
  );

  axis_issue_slot u_dvs (
    .clk    (clk),
    .reset  (reset),
    .start  (accept),
    .tready (uns ? u_dvs_tready : s_dvs_tready),
    .tvalid (dvs_v),
    .hs     (dvs_hs),
    .done   (dvs_done)
  );

  assign s_dvd_tvalid = dvd_v & ~uns;
  assign s_dvs_tvalid = dvs_v & ~uns;
  assign u_dvd_tvalid = dvd_v & uns;
  assign u_dvs_tvalid = dvs_v & uns;

  assign div_tdata_a = a_q;
  assign div_tdata_b = b_q;

  // the last handshake this cycle counts as done
  assign both_done = (dvd_done | dvd_hs)
                   & (dvs_done | dvs_hs);

  assign dout_v = uns ? u_dout_tvalid : s_dout_tvalid;
  assign dout_d = uns ? u_dout_tdata  : s_dout_tdata;

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign resp_valid  = (state_q == DONE);
  assign resp_result = res_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept) state_d = ISSUE;
      ISSUE:
        if (both_done)
          state_d = (pend_q | flush) ? DRAIN : WAIT;
      WAIT:
        if (dout_v)
          state_d = (pend_q | flush) ? IDLE : DONE;
        else if (flush)
          state_d = DRAIN;
      DRAIN:
        if (dout_v) state_d = IDLE;
      DONE:
        if (resp_ready | flush) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= req_op;
        a_q    <= req_src1;
        b_q    <= req_src2;
        pend_q <= 1'b0;
      end
      if (state_q == ISSUE && flush)
        pend_q <= 1'b1;
      if (state_q == WAIT && dout_v
          && !(pend_q | flush))
        res_q <= op_is_quot(op_q)
               ? dout_d[2*DW-1:DW]
               : dout_d[DW-1:0];
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl.
// Behavioural divider IPs with fixed latency; directed vectors.
module tb_div_ctrl;

  localparam int DW = 32;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [DW-1:0] req_src1, req_src2;
  logic          flush;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_result;
  logic          busy;
  logic [DW-1:0] div_tdata_a, div_tdata_b;
  logic          s_dvd_tvalid, s_dvs_tvalid;
  logic          s_dvd_tready, s_dvs_tready;
  logic [2*DW-1:0] s_dout_tdata;
  logic          s_dout_tvalid;
  logic          u_dvd_tvalid, u_dvs_tvalid;
  logic          u_dvd_tready, u_dvs_tready;
  logic [2*DW-1:0] u_dout_tdata;
  logic          u_dout_tvalid;
  logic          s_spur, u_spur;

  always #5 clk = ~clk;

  div_ctrl #(.DW(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_src1      (req_src1),
    .req_src2      (req_src2),
    .flush         (flush),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_result   (resp_result),
    .busy          (busy),
    .div_tdata_a   (div_tdata_a),
    .div_tdata_b   (div_tdata_b),
    .s_dvd_tvalid  (s_dvd_tvalid),
    .s_dvs_tvalid  (s_dvs_tvalid),
    .s_dvd_tready  (s_dvd_tready),
    .s_dvs_tready  (s_dvs_tready),
    .s_dout_tdata  (s_dout_tdata),
    .s_dout_tvalid (s_dout_tvalid),
    .u_dvd_tvalid  (u_dvd_tvalid),
    .u_dvs_tvalid  (u_dvs_tvalid),
    .u_dvd_tready  (u_dvd_tready),
    .u_dvs_tready  (u_dvs_tready),
    .u_dout_tdata  (u_dout_tdata),
    .u_dout_tvalid (u_dout_tvalid)
  );

  // ---- behavioural divider IPs ----
  function automatic logic [63:0] sdiv(
    input logic [31:0] a, input logic [31:0] b
  );
    logic signed [31:0] q, r;
    if (b == 0) return {32'hFFFF_FFFF, a};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {q, r};
  endfunction

  function automatic logic [63:0] udiv(
    input logic [31:0] a, input logic [31:0] b
  );
    if (b == 0) return {32'hFFFF_FFFF, a};
    return {a / b, a % b};
  endfunction

  int s_cnt, u_cnt;
  logic s_ga, s_gb, u_ga, u_gb;
  logic [63:0] s_res, u_res;
  logic s_ha, s_hb, u_ha, u_hb;

  assign s_ha = s_dvd_tvalid & s_dvd_tready;
  assign s_hb = s_dvs_tvalid & s_dvs_tready;
  assign u_ha = u_dvd_tvalid & u_dvd_tready;
  assign u_hb = u_dvs_tvalid & u_dvs_tready;

  assign s_dout_tvalid = (s_cnt == 1) | s_spur;
  assign u_dout_tvalid = (u_cnt == 1) | u_spur;
  assign s_dout_tdata  = s_res;
  assign u_dout_tdata  = u_res;

  always @(posedge clk) begin
    if (reset) begin
      s_cnt <= 0; s_ga <= 0; s_gb <= 0;
      u_cnt <= 0; u_ga <= 0; u_gb <= 0;
      s_res <= '0; u_res <= '0;
    end else begin
      if (s_cnt != 0) s_cnt <= s_cnt - 1;
      if (u_cnt != 0) u_cnt <= u_cnt - 1;
      if ((s_ga | s_ha) && (s_gb | s_hb)) begin
        s_ga <= 0; s_gb <= 0; s_cnt <= LAT;
        s_res <= sdiv(div_tdata_a, div_tdata_b);
      end else begin
        if (s_ha) s_ga <= 1;
        if (s_hb) s_gb <= 1;
      end
      if ((u_ga | u_ha) && (u_gb | u_hb)) begin
        u_ga <= 0; u_gb <= 0; u_cnt <= LAT;
        u_res <= udiv(div_tdata_a, div_tdata_b);
      end else begin
        if (u_ha) u_ga <= 1;
        if (u_hb) u_gb <= 1;
      end
    end
  end

  // ---- checking helpers ----
  int checks = 0;
  int errors = 0;
  int n;
  bit wrong_unit;
  bit rv_seen;
  logic exp_uns;

  task automatic chk(
    input string nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h",
               nm, got, exp);
    end
  endtask

  // one negedge; watches the unit that must stay idle
  task automatic step();
    @(negedge clk);
    n++;
    if (exp_uns ? (s_dvd_tvalid | s_dvs_tvalid)
                : (u_dvd_tvalid | u_dvs_tvalid))
      wrong_unit = 1;
    if (resp_valid) rv_seen = 1;
    s_spur = exp_uns && (n == 3);
  endtask

  task automatic send(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int k;
    k = 0;
    @(negedge clk);
    req_valid = 1; req_op = op;
    req_src1 = a; req_src2 = b;
    while (!req_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid = 0;
    n = 0; wrong_unit = 0; rv_seen = 0;
    exp_uns = op[2] | op[3];
  endtask

  task automatic wait_resp();
    while (!resp_valid && n < 60) step();
    if (!resp_valid) chk("resp_timeout", 0, 1);
  endtask

  task automatic wait_ready();
    while (!req_ready && n < 60) step();
    if (!req_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic release_resp();
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ctl"},
        {25'd0, req_ready, resp_valid, busy,
         s_dvd_tvalid, s_dvs_tvalid,
         u_dvd_tvalid, u_dvs_tvalid},
        32'b100_0000);
    chk({nm, "_result"}, resp_result, 0);
    chk({nm, "_tdata"},
        div_tdata_a | div_tdata_b, 0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam logic [3:0] DIV  = 4'b0001;
  localparam logic [3:0] MOD  = 4'b0010;
  localparam logic [3:0] UDIV = 4'b0100;
  localparam logic [3:0] UMOD = 4'b1000;

  vec_t vt [8];
  logic [31:0] hold;
  bit   stable;

  initial begin
    vt[0] = '{DIV,  32'hFFFF_FFF9, 2,   32'hFFFF_FFFD};
    vt[1] = '{UMOD, 32'hFFFF_FFFF, 10,  32'd5};
    vt[2] = '{MOD,  32'hFFFF_FFF9, 2,   32'hFFFF_FFFF};
    vt[3] = '{UDIV, 32'hFFFF_FFFF, 10,  32'h1999_9999};
    vt[4] = '{DIV,  32'd100, 32'hFFFF_FFF9,
              32'hFFFF_FFF2};
    vt[5] = '{MOD,  32'd17,  32'd5, 32'd2};
    vt[6] = '{DIV,  32'd5,   32'd0, 32'hFFFF_FFFF};
    vt[7] = '{UDIV, 32'h8000_0000, 2,
              32'h4000_0000};

    reset = 1; req_valid = 0; req_op = 0;
    req_src1 = 0; req_src2 = 0; flush = 0;
    resp_ready = 0; s_spur = 0; u_spur = 0;
    s_dvd_tready = 1; s_dvs_tready = 1;
    u_dvd_tready = 1; u_dvs_tready = 1;
    exp_uns = 0; n = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 0;

    // stray IP outputs in IDLE are ignored
    @(negedge clk);
    s_spur = 1; u_spur = 1;
    @(negedge clk);
    s_spur = 0; u_spur = 0;
    @(negedge clk);
    chk("idle_spur",
        {30'd0, busy, resp_valid}, 0);

    // table: result, latency, unit routing
    for (int i = 0; i < 8; i++) begin
      send(vt[i].op, vt[i].a, vt[i].b);
      wait_resp();
      chk($sformatf("v%0d_result", i),
          resp_result, vt[i].exp);
      chk($sformatf("v%0d_latency", i),
          n, 2 + LAT);
      chk($sformatf("v%0d_unit", i),
          {31'd0, wrong_unit}, 0);
      release_resp();
      chk($sformatf("v%0d_ready", i),
          {31'd0, req_ready}, 1);
    end

    // divisor tready held low 3 cycles
    s_dvs_tready = 0;
    send(DIV, 32'd100, 32'd7);
    step();
    chk("stall_both_v",
        {30'd0, s_dvd_tvalid, s_dvs_tvalid}, 3);
    step();
    chk("stall_dvd_drop",
        {30'd0, s_dvd_tvalid, s_dvs_tvalid}, 1);
    step();
    step();
    chk("stall_dvs_hold",
        {30'd0, s_dvd_tvalid, s_dvs_tvalid}, 1);
    chk("stall_tdata_b", div_tdata_b, 7);
    s_dvs_tready = 1;
    step();
    chk("stall_dvs_drop",
        {31'd0, s_dvs_tvalid}, 0);
    wait_resp();
    chk("stall_latency", n, 9);
    chk("stall_result", resp_result, 14);
    release_resp();

    // flush in WAIT: drained, never responds
    send(DIV, 32'd20, 32'd3);
    step();
    step();
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    wait_ready();
    chk("fwait_ready_n", n, 6);
    chk("fwait_no_resp", {31'd0, rv_seen}, 0);

    // flush in ISSUE with tready low
    s_dvd_tready = 0; s_dvs_tready = 0;
    send(DIV, 32'd9, 32'd2);
    step();
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    step();
    step();
    chk("fissue_hold",
        {30'd0, s_dvd_tvalid, s_dvs_tvalid}, 3);
    chk("fissue_tdata_a", div_tdata_a, 9);
    s_dvd_tready = 1; s_dvs_tready = 1;
    wait_ready();
    chk("fissue_ready_n", n, 8);
    chk("fissue_no_resp", {31'd0, rv_seen}, 0);
    send(MOD, 32'd17, 32'd5);
    wait_resp();
    chk("after_flush_result", resp_result, 2);
    release_resp();

    // response backpressure
    send(UDIV, 32'd100, 32'd7);
    wait_resp();
    hold = resp_result;
    stable = 1;
    repeat (5) begin
      step();
      if (!resp_valid || resp_result !== hold)
        stable = 0;
    end
    chk("bp_result", hold, 14);
    chk("bp_stable", {31'd0, stable}, 1);
    release_resp();
    chk("bp_ready", {31'd0, req_ready}, 1);

    // reset while waiting for the IP
    send(DIV, 32'd8, 32'd2);
    step();
    step();
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    step();
    chk_reset_vals("midreset");
    send(DIV, 32'd8, 32'd2);
    wait_resp();
    chk("post_reset_result", resp_result, 4);
    release_resp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
